// File: rtl/mastermind_guess_entry.sv
// mastermind_guess_entry: debounced push-button entry of four 4-digit guesses for the display stage.
// Define MASTERMIND_AUTOREPEAT_EN to auto-repeat held up/down buttons.
module mastermind_guess_entry #(
  parameter int DIGIT_MAX  = 7,
  parameter int DEB_CYCLES = 200000,
  parameter int DEB_W      = 18,
  parameter int REP_DELAY  = 20000000,
  parameter int REP_PERIOD = 8000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_ok,
  input  logic             btn_clr,
  output logic [3:0][3:0]  nums [0:3],
  output logic [1:0]       curr_num,
  output logic [1:0]       curr_col,
  output logic [3:0]       locked,
  output logic             done
);
  typedef enum logic [1:0] {EDIT, COMMIT, DONE} state_t;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [3:0] DMAX = 4'(DIGIT_MAX);
  logic [5:0] raw, sync1, sync2, deb, deb_q, flip, press;
  logic [DEB_W-1:0] cnt [0:5];
  logic [1:0] rep_fire;
  logic up, down;
  state_t state, state_n;
  logic [3:0][3:0] nums_n [0:3];
  logic [1:0] num_n, col_n, idx;
  logic [3:0] locked_n, digit;
  logic done_n;
  assign raw = {btn_clr, btn_ok, btn_right, btn_left, btn_down, btn_up};
  // the level flips on the DEB_CYCLES-th consecutive mismatching cycle
  for (genvar i = 0; i < 6; i++) begin : g_flip
    assign flip[i] = (sync2[i] ^ deb[i]) & (cnt[i] == DEB_LAST);
  end
  assign press = deb & ~deb_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb <= '0;
      deb_q <= '0;
      for (int i = 0; i < 6; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb <= deb ^ flip;
      deb_q <= deb;
      for (int i = 0; i < 6; i++) cnt[i] <= (sync2[i] == deb[i] || flip[i]) ? '0 : cnt[i] + 1'b1;
    end
`ifdef MASTERMIND_AUTOREPEAT_EN
  for (genvar i = 0; i < 2; i++) begin : g_rep
    logic [31:0] cnt_r;
    logic on, held;
    assign held = deb[i] & deb_q[i];
    assign rep_fire[i] = held && cnt_r == (on ? 32'(REP_PERIOD - 1) : 32'(REP_DELAY - 1));
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        cnt_r <= '0;
        on <= 1'b0;
      end else if (!held || rep_fire[i]) begin
        cnt_r <= '0;
        on <= held;
      end else
        cnt_r <= cnt_r + 1'b1;
  end
`else
  logic unused_rep;
  assign rep_fire = 2'b00;
  assign unused_rep = ^{REP_DELAY, REP_PERIOD};
`endif
  assign up = press[0] | rep_fire[0];
  assign down = press[1] | rep_fire[1];
  always_comb begin
    state_n = state;
    nums_n = nums;
    num_n = curr_num;
    col_n = curr_col;
    locked_n = locked;
    done_n = done;
    idx = 2'd3 - curr_col;
    digit = nums[curr_num][idx];
    if (state == COMMIT) begin
      state_n = (curr_num == 2'd3) ? DONE : EDIT;
      done_n = curr_num == 2'd3;
      num_n = (curr_num == 2'd3) ? curr_num : curr_num + 2'd1;
      col_n = (curr_num == 2'd3) ? curr_col : 2'd0;
    end else if (press[5]) begin
      state_n = EDIT;
      nums_n = '{default: '0};
      num_n = '0;
      col_n = '0;
      locked_n = '0;
      done_n = 1'b0;
    end else if (state == EDIT) begin
      if (press[4]) begin
        locked_n[curr_num] = 1'b1;
        state_n = COMMIT;
      end else if (up)
        nums_n[curr_num][idx] = (digit == DMAX) ? 4'd0 : digit + 4'd1;
      else if (down)
        nums_n[curr_num][idx] = (digit == 4'd0) ? DMAX : digit - 4'd1;
      else if (press[2])
        col_n = curr_col - 2'd1;
      else if (press[3])
        col_n = curr_col + 2'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= EDIT;
      nums <= '{default: '0};
      curr_num <= '0;
      curr_col <= '0;
      locked <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      nums <= nums_n;
      curr_num <= num_n;
      curr_col <= col_n;
      locked <= locked_n;
      done <= done_n;
    end
endmodule

// File: tb/tb_mastermind_guess_entry.sv
// tb_mastermind_guess_entry: random and directed button stimulus against a game-level reference model.
// Every visible output change is matched, value and cycle, against the model's queued predictions.
module tb_mastermind_guess_entry;
  localparam int DMAX = 7;
  localparam int DEB = 4;
  localparam logic [5:0] UP = 6'd1, DN = 6'd2, LF = 6'd4, RT = 6'd8, OK = 6'd16, CL = 6'd32;
  typedef struct packed {
    logic [3:0][3:0][3:0] d;
    logic [1:0] row;
    logic [1:0] col;
    logic [3:0] lk;
    logic dn;
  } snap_t;
  typedef struct packed {
    snap_t s;
    logic [31:0] cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] btns = '0;
  logic [3:0][3:0] nums [0:3];
  logic [1:0] curr_num, curr_col;
  logic [3:0] locked;
  logic done;
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  exp_t exp_q[$];
  mastermind_guess_entry #(.DIGIT_MAX(DMAX), .DEB_CYCLES(DEB), .DEB_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btns[0]), .btn_down(btns[1]), .btn_left(btns[2]),
    .btn_right(btns[3]), .btn_ok(btns[4]), .btn_clr(btns[5]),
    .nums(nums), .curr_num(curr_num), .curr_col(curr_col), .locked(locked), .done(done)
  );
  always #5 clk = ~clk;
  // cyc holds the index of the most recent rising edge minus one from that edge until the next falling edge
  always @(negedge clk) cyc <= cyc + 1;
  int dg [4][4] = '{default: 0};
  int row = 0, col = 0;
  logic [3:0] lk = '0;
  logic dn = 1'b0, commit_p = 1'b0;
  logic [15:0] h [6] = '{default: '0};
  logic [5:0] lvl = '0, pend = '0;
  snap_t last = '1, before_last = '1;
  function automatic snap_t msnap();
    snap_t s;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s.d[r][c] = 4'(dg[r][c]);
    s.row = 2'(row);
    s.col = 2'(col);
    s.lk = lk;
    s.dn = dn;
    return s;
  endfunction
  function automatic snap_t dsnap();
    snap_t s;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s.d[r][c] = nums[r][3-c];
    s.row = curr_num;
    s.col = curr_col;
    s.lk = locked;
    s.dn = done;
    return s;
  endfunction
  task automatic clear_game();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) dg[r][c] = 0;
    row = 0;
    col = 0;
    lk = '0;
    dn = 1'b0;
    commit_p = 1'b0;
  endtask
  task automatic act(input logic [5:0] p);
    if (commit_p) begin
      commit_p = 1'b0;
      if (row == 3) dn = 1'b1;
      else begin
        row++;
        col = 0;
      end
    end else if (p[5]) clear_game();
    else if (!dn) begin
      if (p[4]) begin
        lk[row] = 1'b1;
        commit_p = 1'b1;
      end else if (p[0]) dg[row][col] = (dg[row][col] + 1) % (DMAX + 1);
      else if (p[1]) dg[row][col] = (dg[row][col] + DMAX) % (DMAX + 1);
      else if (p[2]) col = (col + 3) % 4;
      else if (p[3]) col = (col + 1) % 4;
    end
  endtask
  task automatic note(input int stamp);
    snap_t cur;
    cur = msnap();
    if (exp_q.size() > 0 && int'(exp_q[$].cyc) == stamp) begin
      void'(exp_q.pop_back());
      last = before_last;
    end
    if (cur !== last) begin
      exp_q.push_back('{s: cur, cyc: 32'(stamp)});
      before_last = last;
      last = cur;
    end
  endtask
  // a button level is accepted once DEB samples, seen two cycles late, all disagree with it
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clear_game();
      for (int b = 0; b < 6; b++) h[b] = '0;
      lvl = '0;
      pend = '0;
    end else begin
      act(pend);
      pend = '0;
      for (int b = 0; b < 6; b++) begin
        h[b] = {h[b][14:0], btns[b]};
        if (h[b][DEB+1:2] == {DEB{~lvl[b]}}) begin
          pend[b] = ~lvl[b];
          lvl[b] = ~lvl[b];
        end
      end
    end
    note(cyc);
  end
  snap_t prev = '1;
  logic fin = 1'b0, flushed = 1'b0;
  always @(negedge clk) begin
    snap_t cur;
    exp_t e;
    cur = dsnap();
    if (cur !== prev) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_change @%0d got=%h", cyc, cur);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e.s || cyc != int'(e.cyc)) begin
          mismatched++;
          $display("FAIL outputs @%0d got=%h want=%h @%0d", cyc, cur, e.s, e.cyc);
        end
      end
      prev = cur;
    end
    if (fin && !flushed) begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compared++;
        mismatched++;
        $display("FAIL missing_change got=none want=%h @%0d", e.s, e.cyc);
      end
      flushed = 1'b1;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic hold(input logic [5:0] m, input int n);
    btns = m;
    repeat (n) step();
  endtask
  task automatic press(input logic [5:0] m);
    hold(m, 10);
    hold('0, 10);
  endtask
  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) press(UP);
    hold(UP, 3);
    hold('0, 1);
    hold(UP, 3);
    hold('0, 10);
    hold(UP, 7);
    hold('0, 10);
    press(CL);
    press(DN);
    press(UP);
    for (int i = 0; i < 4; i++) press(RT);
    press(LF);
    press(UP);
    for (int i = 0; i < 4; i++) begin
      press(UP);
      press(RT);
      press(UP);
      press(OK);
    end
    press(UP);
    press(LF);
    press(CL);
    press(UP);
    press(OK | UP);
    btns = UP;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (10) step();
    hold('0, 10);
    for (int i = 0; i < 250; i++) begin
      logic [5:0] m;
      m = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 31)) : 6'(1 << $urandom_range(0, 4));
      if ($urandom_range(0, 14) == 0) m |= CL;
      hold(m, int'($urandom_range(1, 9)));
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      hold('0, int'($urandom_range(0, 9)));
    end
    hold('0, 20);
    fin = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
